// File: rtl/ram_pkg.sv
// +-------------------------------------------------------------------+
// | ram_pkg : shared encodings and helpers for data_ram_ctrl           |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

package ram_pkg;

  localparam logic [2:0] MEMC_B  = 3'd0;
  localparam logic [2:0] MEMC_H  = 3'd1;
  localparam logic [2:0] MEMC_W  = 3'd2;
  localparam logic [2:0] MEMC_BS = 3'd3;
  localparam logic [2:0] MEMC_HS = 3'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  function automatic logic [3:0] size_mask(input logic [2:0] memc);
    logic [3:0] m;
    case (memc)
      MEMC_B, MEMC_BS: m = 4'b0001;
      MEMC_H, MEMC_HS: m = 4'b0011;
      default:         m = 4'b1111;
    endcase
    return m;
  endfunction

  // Access size minus one, in bytes.
  function automatic logic [1:0] size_last(input logic [2:0] memc);
    logic [1:0] n;
    case (memc)
      MEMC_B, MEMC_BS: n = 2'd0;
      MEMC_H, MEMC_HS: n = 2'd1;
      default:         n = 2'd3;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] memc, input logic [31:0] d);
    logic [31:0] r;
    case (memc)
      MEMC_B:  r = {24'd0, d[7:0]};
      MEMC_H:  r = {16'd0, d[15:0]};
      MEMC_BS: r = {{24{d[7]}}, d[7:0]};
      MEMC_HS: r = {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_bank.sv
// +-------------------------------------------------------------------+
// | ram_bank : DEPTH_WORDS x 32 array, byte-enabled synchronous write, |
// |            combinational read of the addressed word.               |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module ram_bank #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          CLK,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

`default_nettype wire

// File: rtl/data_ram_ctrl.sv
// +-------------------------------------------------------------------+
// | data_ram_ctrl : byte-addressed data memory with valid/ready request |
// |                 port, optional two-beat misaligned access.         |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module data_ram_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH_WORDS    = 64,
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_memc,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int              AW        = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] BYTES_LIM = (ADDR_W + 1)'(4 * DEPTH_WORDS);

  state_t          state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      memc_q, memc_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [AW-1:0]   w1_q, w1_d;
  logic [31:0]     w0_q, w0_d;

  logic [AW-1:0]   bank_addr;
  logic [3:0]      bank_be;
  logic [31:0]     bank_wdata;
  logic [31:0]     bank_rdata;

  logic            accept;
  logic [1:0]      off;
  logic [3:0]      mask;
  logic [AW-1:0]   w_idx;
  logic [ADDR_W:0] last_byte;
  logic            misaligned;
  logic            illegal;
  logic            out_of_range;
  logic            err;
  logic [3:0]      be_lo;
  logic [31:0]     wd_lo;
  logic [31:0]     ld_aligned;
  logic [3:0]      be_hi;
  logic [31:0]     wd_hi;
  logic [31:0]     ld_window;

  ram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bank (
    .CLK   (CLK),
    .addr  (bank_addr),
    .be    (bank_be),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  // Request decode and error classification, evaluated on the live request.
  always_comb begin
    accept       = req_valid && req_ready_q;
    off          = req_addr[1:0];
    mask         = size_mask(req_memc);
    w_idx        = req_addr[AW+1:2];
    last_byte    = {1'b0, req_addr} + {{(ADDR_W - 1){1'b0}}, size_last(req_memc)};
    misaligned   = ((mask == 4'b0011) && (off == 2'd3)) ||
                   ((mask == 4'b1111) && (off != 2'd0));
    illegal      = (req_memc > MEMC_HS) ||
                   (req_we && ((req_memc == MEMC_BS) || (req_memc == MEMC_HS)));
    out_of_range = (last_byte >= BYTES_LIM);
    err          = illegal || out_of_range || (misaligned && !MISALIGN_SPLIT);
    be_lo        = mask << off;
    wd_lo        = req_wdata << {off, 3'b000};
    ld_aligned   = bank_rdata >> {off, 3'b000};
  end

  // Second-beat lanes come from the bytes that spilled past lane 3.
  always_comb begin
    be_hi     = size_mask(memc_q) >> (3'd4 - {1'b0, off_q});
    wd_hi     = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
    ld_window = 32'({bank_rdata, w0_q} >> {off_q, 3'b000});
  end

  always_comb begin
    bank_addr  = w_idx;
    bank_be    = 4'b0000;
    bank_wdata = wd_lo;
    if (state_q == SPLIT) begin
      bank_addr  = w1_q;
      bank_be    = we_q ? be_hi : 4'b0000;
      bank_wdata = wd_hi;
    end else if (accept && req_we && !err) begin
      bank_be = be_lo;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = 1'b1;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;
    off_d       = off_q;
    memc_d      = memc_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    w1_d        = w1_q;
    w0_d        = w0_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (misaligned) begin
            state_d     = SPLIT;
            req_ready_d = 1'b0;
            off_d       = off;
            memc_d      = req_memc;
            we_d        = req_we;
            wdata_d     = req_wdata;
            w1_d        = w_idx + 1'b1;
            w0_d        = bank_rdata;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_we ? 32'd0 : extend_load(req_memc, ld_aligned);
          end
        end
      end
      SPLIT: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? 32'd0 : extend_load(memc_q, ld_window);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      off_q       <= 2'd0;
      memc_q      <= MEMC_B;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      w1_q        <= '0;
      w0_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      off_q       <= off_d;
      memc_q      <= memc_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      w1_q        <= w1_d;
      w0_q        <= w0_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
// +-------------------------------------------------------------------+
// | tb_data_ram_ctrl : directed bench for split and non-split builds   |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_data_ram_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_memc;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        sel_ns;

  logic        v_s, v_n;
  logic        rdy_s, rdy_n, vld_s, vld_n, err_s, err_n;
  logic [31:0] rd_s, rd_n;
  logic        rdy, vld, err;
  logic [31:0] rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  assign v_s = req_valid & ~sel_ns;
  assign v_n = req_valid & sel_ns;
  assign rdy = sel_ns ? rdy_n : rdy_s;
  assign vld = sel_ns ? vld_n : vld_s;
  assign err = sel_ns ? err_n : err_s;
  assign rd  = sel_ns ? rd_n  : rd_s;

  data_ram_ctrl #(.DEPTH_WORDS(64), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(v_s), .req_ready(rdy_s), .req_we(req_we),
    .req_memc(req_memc), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld_s), .rsp_rdata(rd_s), .rsp_err(err_s)
  );

  data_ram_ctrl #(.DEPTH_WORDS(64), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) dut_ns (
    .CLK(CLK), .RESET(RESET), .req_valid(v_n), .req_ready(rdy_n), .req_we(req_we),
    .req_memc(req_memc), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld_n), .rsp_rdata(rd_n), .rsp_err(err_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; lat counts edges from accept to the first rsp_valid (capped).
  task automatic xfer(input logic we, input logic [2:0] memc, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic e, output int lat, output logic rdy_after);
    @(negedge CLK);
    req_we    = we;
    req_memc  = memc;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    rdy_after = rdy;
    lat       = 1;
    while (!vld && lat < 6) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    rdata = rd;
    e     = err;
  endtask

  task automatic ld(input string tag, input logic [2:0] memc, input logic [31:0] addr,
                    input logic [31:0] exp, input int exp_lat);
    logic [31:0] r; logic e; int lat; logic ra;
    xfer(1'b0, memc, addr, 32'd0, r, e, lat, ra);
    check({tag, "_data"}, r, exp);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, {31'd0, e}, 32'd0);
  endtask

  task automatic st(input string tag, input logic [2:0] memc, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic exp_err, input int exp_lat);
    logic [31:0] r; logic e; int lat; logic ra;
    xfer(1'b1, memc, addr, wdata, r, e, lat, ra);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, r, 32'd0);
  endtask

  task automatic req_err(input string tag, input logic we, input logic [2:0] memc,
                         input logic [31:0] addr);
    logic [31:0] r; logic e; int lat; logic ra;
    xfer(we, memc, addr, 32'hFFFF_FFFF, r, e, lat, ra);
    check({tag, "_err"}, {31'd0, e}, 32'd1);
    check({tag, "_data"}, r, 32'd0);
    check({tag, "_lat"}, lat, 1);
  endtask

  initial begin
    logic [31:0] r; logic e; int lat; logic ra;
    RESET     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_memc  = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    sel_ns    = 1'b0;
    #12;
    check("rst_ready", {31'd0, rdy}, 32'd1);
    check("rst_valid", {31'd0, vld}, 32'd0);
    check("rst_rdata", rd, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready_ns", {31'd0, rdy_n}, 32'd1);
    @(negedge CLK);
    RESET = 1'b0;

    // Aligned store then extended loads.
    st("st_w10", 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0, 1);
    ld("ld_bs11", 3'd3, 32'h11, 32'hFFFF_FFBE, 1);
    ld("ld_h12", 3'd1, 32'h12, 32'h0000_DEAD, 1);
    ld("ld_b10", 3'd0, 32'h10, 32'h0000_00EF, 1);
    ld("ld_hs12", 3'd4, 32'h12, 32'hFFFF_DEAD, 1);

    // Back-to-back store byte / load byte.
    @(negedge CLK);
    req_we = 1'b1; req_memc = 3'd0; req_addr = 32'h20; req_wdata = 32'h0000_005A;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    check("b2b_ready0", {31'd0, rdy}, 32'd1);
    check("b2b_valid0", {31'd0, vld}, 32'd1);
    check("b2b_err0", {31'd0, err}, 32'd0);
    req_we = 1'b0;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    check("b2b_ready1", {31'd0, rdy}, 32'd1);
    check("b2b_valid1", {31'd0, vld}, 32'd1);
    check("b2b_rdata1", rd, 32'h0000_005A);
    @(posedge CLK);
    #1;
    check("b2b_valid2", {31'd0, vld}, 32'd0);

    // Split store word at 0x07, then read back.
    xfer(1'b1, 3'd2, 32'h07, 32'h1122_3344, r, e, lat, ra);
    check("sp_st_ready", {31'd0, ra}, 32'd0);
    check("sp_st_lat", lat, 2);
    check("sp_st_err", {31'd0, e}, 32'd0);
    ld("sp_b07", 3'd0, 32'h07, 32'h44, 1);
    ld("sp_b08", 3'd0, 32'h08, 32'h33, 1);
    ld("sp_b09", 3'd0, 32'h09, 32'h22, 1);
    ld("sp_b0a", 3'd0, 32'h0A, 32'h11, 1);
    ld("sp_w07", 3'd2, 32'h07, 32'h1122_3344, 2);
    ld("sp_h07", 3'd1, 32'h07, 32'h0000_3344, 2);
    ld("sp_h09", 3'd1, 32'h09, 32'h0000_1122, 1);

    // Non-split build rejects misaligned accesses.
    sel_ns = 1'b1;
    st("ns_w00", 3'd2, 32'h00, 32'hA3A2_A1A0, 1'b0, 1);
    st("ns_w04", 3'd2, 32'h04, 32'hB3B2_B1B0, 1'b0, 1);
    st("ns_h03", 3'd1, 32'h03, 32'h0000_C0C1, 1'b1, 1);
    ld("ns_b03", 3'd0, 32'h03, 32'hA3, 1);
    ld("ns_b04", 3'd0, 32'h04, 32'hB0, 1);
    req_err("ns_ldw01", 1'b0, 3'd2, 32'h01);
    sel_ns = 1'b0;

    // Error cases and range boundary.
    req_err("e_ldw100", 1'b0, 3'd2, 32'h100);
    req_err("e_stbs", 1'b1, 3'd3, 32'h20);
    req_err("e_memc6", 1'b0, 3'd6, 32'h20);
    req_err("e_ldwfe", 1'b0, 3'd2, 32'hFE);
    req_err("e_hiaddr", 1'b0, 3'd0, 32'h8000_0020);
    xfer(1'b0, 3'd0, 32'hFF, 32'd0, r, e, lat, ra);
    check("e_ldbff_err", {31'd0, e}, 32'd0);
    ld("e_b20_kept", 3'd0, 32'h20, 32'h5A, 1);

    // Reset during the SPLIT beat of a store.
    st("rs_w0c", 3'd2, 32'h0C, 32'h0000_0000, 1'b0, 1);
    st("rs_w10", 3'd2, 32'h10, 32'h7777_7777, 1'b0, 1);
    @(negedge CLK);
    req_we = 1'b1; req_memc = 3'd2; req_addr = 32'h0E; req_wdata = 32'hAABB_CCDD;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    check("rs_ready_split", {31'd0, rdy}, 32'd0);
    RESET = 1'b1;
    #1;
    check("rs_ready_async", {31'd0, rdy}, 32'd1);
    @(posedge CLK);
    #1;
    check("rs_valid_a", {31'd0, vld}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("rs_valid_b", {31'd0, vld}, 32'd0);
    ld("rs_w0c", 3'd2, 32'h0C, 32'hCCDD_0000, 1);
    ld("rs_w10", 3'd2, 32'h10, 32'h7777_7777, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
